// File: rtl/add_sub_pkg.sv
// rtl/add_sub_pkg.sv - shared types and constants for the digit-serial adder/subtractor
package add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int GROUP_W = 4;

endpackage

// File: rtl/cla_group4.sv
// rtl/cla_group4.sv - combinational 4-bit carry-look-ahead group
module cla_group4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c,
    output logic [3:0] sum,
    output logic [3:1] ci,
    output logic       co
);

    logic [3:0] g;
    logic [3:0] p;

    // Generate/propagate terms and flattened look-ahead carries from the group carry-in
    always_comb begin
        g     = a & b;
        p     = a ^ b;
        ci[1] = g[0] | (p[0] & c);
        ci[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        ci[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
        co    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c);
        sum   = p ^ {ci[3:1], c};
    end

endmodule

// File: rtl/digit_serial_add_sub.sv
// rtl/digit_serial_add_sub.sv - multi-cycle adder/subtractor resolving one 4-bit group per cycle
module digit_serial_add_sub
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NGROUPS = WIDTH / GROUP_W;
    localparam int GRP_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NGROUPS - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               c_q, c_d;
    logic [GRP_W-1:0]   grp_q, grp_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [GROUP_W-1:0] grp_a;
    logic [GROUP_W-1:0] grp_b;
    logic [GROUP_W-1:0] grp_sum;
    logic [3:1]         grp_ci;
    logic               grp_co;

    // Slice of the held operands for the group being resolved this cycle
    assign grp_a = a_q[int'(grp_q) * GROUP_W +: GROUP_W];
    assign grp_b = b_q[int'(grp_q) * GROUP_W +: GROUP_W];

    cla_group4 u_cla (
        .a   (grp_a),
        .b   (grp_b),
        .c   (c_q),
        .sum (grp_sum),
        .ci  (grp_ci),
        .co  (grp_co)
    );

    // Accept in IDLE only; rst_n gating keeps in_ready low throughout reset
    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    // Next-state: operand capture, per-group carry ripple, result capture and handoff
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        grp_d   = grp_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is A + ~B + ~borrow, so invert B and the carry-in once here
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    c_d     = cin ^ sub;
                    grp_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                sum_d[int'(grp_q) * GROUP_W +: GROUP_W] = grp_sum;
                c_d   = grp_co;
                grp_d = grp_q + GRP_W'(1);
                if (grp_q == LAST_GRP) begin
                    // Signed overflow: carry into the MSB differs from carry out of it
                    cout_d  = grp_co;
                    ovf_d   = grp_ci[3] ^ grp_co;
                    grp_d   = grp_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            grp_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            grp_q   <= grp_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_digit_serial_add_sub.sv
// tb/tb_digit_serial_add_sub.sv - directed self-checking bench for digit_serial_add_sub
module tb_digit_serial_add_sub;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    digit_serial_add_sub #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands, accept, scramble inputs, wait for the result and check it.
    // When release_out is 0 the op is left sitting in DONE.
    task automatic start_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                            input logic sv, input logic cv, input logic [15:0] exp_sum,
                            input logic exp_cout, input logic exp_ovf, input bit release_out);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a        = av;
        b        = bv;
        sub      = sv;
        cin      = cv;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a        = ~av;
        b        = 16'hA5C3;
        sub      = ~sv;
        cin      = ~cv;
        check_eq({tag, "_busy_rdy"}, 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check_eq({tag, "_latency"}, 32'(n), 32'd4);
        check_eq({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        check_eq({tag, "_cout"}, 32'(cout), 32'(exp_cout));
        check_eq({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        if (release_out) begin
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            check_eq({tag, "_drain"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        cin       = 1'b0;
        #2;
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_sum", 32'(sum), 32'd0);
        check_eq("rst_flags", 32'({cout, ovf}), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        start_op("add_ff_1",   16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1);
        start_op("sub_5_7",    16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b1);
        start_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
        start_op("sub_ovf",    16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b1);
        start_op("add_ripple", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        start_op("sub_borrow", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, 1'b1);

        // Stall in DONE with in_valid toggling
        start_op("stall", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a        = 16'h0F0F;
            b        = 16'h0101;
            step();
            check_eq("stall_valid", 32'(out_valid), 32'd1);
            check_eq("stall_in_ready", 32'(in_ready), 32'd0);
            check_eq("stall_sum", 32'(sum), 32'h3333);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("stall_release_valid", 32'(out_valid), 32'd0);
        check_eq("stall_release_idle", 32'(in_ready), 32'd1);

        // Reset while the third group is about to be resolved
        a        = 16'hFFFF;
        b        = 16'h0001;
        sub      = 1'b0;
        cin      = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check_eq("abort_valid", 32'(out_valid), 32'd0);
        check_eq("abort_sum", 32'(sum), 32'd0);
        check_eq("abort_flags", 32'({cout, ovf}), 32'd0);
        check_eq("abort_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 2) rst_n = 1'b1;
            check_eq("abort_no_valid", 32'(out_valid), 32'd0);
        end
        start_op("after_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
